// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard unit.
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LU_WAIT = 2'd1,
    MC_BUSY = 2'd2
  } state_e;

  // Register addresses are zero-extended to this width before matching.
  localparam int MAX_AW = 16;
  localparam logic [MAX_AW-1:0] ZERO_REG = '0;

  function automatic logic match_x(
    input logic [MAX_AW-1:0] rd,
    input logic [MAX_AW-1:0] rs1,
    input logic [MAX_AW-1:0] rs2,
    input logic              rs1_used,
    input logic              rs2_used
  );
    return (rd != ZERO_REG) && ((rs1_used && rd == rs1) || (rs2_used && rd == rs2));
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle for the hazard unit: stage register fields in, hold/flush/bubble out.
interface hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic [REG_AW-1:0] ifid_rs1;
  logic [REG_AW-1:0] ifid_rs2;
  logic              ifid_rs1_used;
  logic              ifid_rs2_used;
  logic [REG_AW-1:0] idex_rd;
  logic              idex_regwrite;
  logic              idex_memread;
  logic              idex_mc_op;
  logic              mc_done;
  logic [REG_AW-1:0] exmem_rd;
  logic              exmem_regwrite;
  logic              ex_redirect;
  logic              pc_hold;
  logic              ifid_hold;
  logic              ifid_flush;
  logic              idex_hold;
  logic              idex_bubble;
  logic              exmem_bubble;
  logic [CNT_W-1:0]  stall_cycles;

  modport master (
    output ifid_rs1, ifid_rs2, ifid_rs1_used, ifid_rs2_used,
           idex_rd, idex_regwrite, idex_memread, idex_mc_op, mc_done,
           exmem_rd, exmem_regwrite, ex_redirect,
    input  pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble,
           exmem_bubble, stall_cycles
  );

  modport slave (
    input  ifid_rs1, ifid_rs2, ifid_rs1_used, ifid_rs2_used,
           idex_rd, idex_regwrite, idex_memread, idex_mc_op, mc_done,
           exmem_rd, exmem_regwrite, ex_redirect,
    output pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble,
           exmem_bubble, stall_cycles
  );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (inc && r_count != {W{1'b1}}) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: load-use and RAW stalls, multi-cycle EX busy, branch redirect flush.
// state   | meaning
// IDLE    | no multi-cycle stall in progress; hazards evaluated combinationally
// LU_WAIT | counting out the remaining load-use bubbles in r_lu_cnt
// MC_BUSY | multi-cycle EX op in flight, pipeline frozen until mc_done
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter bit FWD_EN     = 1'b1,
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 16
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave hz
);
  state_e            r_state, w_state_nxt;
  logic [2:0]        r_lu_cnt, w_lu_cnt_nxt;
  logic [REG_AW-1:0] w_rd_ex, w_rd_mem;
  logic              w_match_ex, w_match_mem, w_load_use, w_raw;
  logic              w_pc_hold, w_idex_hold, w_idex_bubble, w_exmem_bubble, w_ifid_flush;

  assign w_rd_ex  = hz.idex_rd;
  assign w_rd_mem = hz.exmem_rd;

  assign w_match_ex  = match_x(MAX_AW'(w_rd_ex), MAX_AW'(hz.ifid_rs1), MAX_AW'(hz.ifid_rs2),
                               hz.ifid_rs1_used, hz.ifid_rs2_used);
  assign w_match_mem = match_x(MAX_AW'(w_rd_mem), MAX_AW'(hz.ifid_rs1), MAX_AW'(hz.ifid_rs2),
                               hz.ifid_rs1_used, hz.ifid_rs2_used);
  assign w_load_use  = hz.idex_memread && hz.idex_regwrite && w_match_ex;
  assign w_raw       = (hz.idex_regwrite && w_match_ex) || (hz.exmem_regwrite && w_match_mem);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_lu_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_lu_cnt <= w_lu_cnt_nxt;
    end
  end

  // Rules are checked in strict priority; redirect is deliberately ignored while MC_BUSY.
  always_comb begin
    w_state_nxt    = r_state;
    w_lu_cnt_nxt   = r_lu_cnt;
    w_pc_hold      = 1'b0;
    w_idex_hold    = 1'b0;
    w_idex_bubble  = 1'b0;
    w_exmem_bubble = 1'b0;
    w_ifid_flush   = 1'b0;
    if (rst) begin
      w_state_nxt  = IDLE;
      w_lu_cnt_nxt = '0;
    end else if (r_state == MC_BUSY || (r_state == IDLE && hz.idex_mc_op && !hz.mc_done)) begin
      if (r_state == MC_BUSY && hz.mc_done) begin
        w_state_nxt = IDLE;
      end else begin
        w_pc_hold      = 1'b1;
        w_idex_hold    = 1'b1;
        w_exmem_bubble = 1'b1;
        w_state_nxt    = MC_BUSY;
      end
    end else if (hz.ex_redirect) begin
      w_ifid_flush  = 1'b1;
      w_idex_bubble = 1'b1;
      w_state_nxt   = IDLE;
      w_lu_cnt_nxt  = '0;
    end else if (r_state == LU_WAIT) begin
      w_pc_hold     = 1'b1;
      w_idex_bubble = 1'b1;
      w_lu_cnt_nxt  = r_lu_cnt - 3'd1;
      if (r_lu_cnt == 3'd1) w_state_nxt = IDLE;
    end else if (r_state == IDLE && w_load_use) begin
      w_pc_hold     = 1'b1;
      w_idex_bubble = 1'b1;
      if (LOAD_STALL > 1) begin
        w_lu_cnt_nxt = 3'(LOAD_STALL - 1);
        w_state_nxt  = LU_WAIT;
      end
    end else if (r_state == IDLE && !FWD_EN && w_raw) begin
      w_pc_hold     = 1'b1;
      w_idex_bubble = 1'b1;
    end
  end

  assign hz.pc_hold      = w_pc_hold;
  assign hz.ifid_hold    = w_pc_hold;
  assign hz.ifid_flush   = w_ifid_flush;
  assign hz.idex_hold    = w_idex_hold;
  assign hz.idex_bubble  = w_idex_bubble;
  assign hz.exmem_bubble = w_exmem_bubble;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_pc_hold),
    .count (hz.stall_cycles)
  );
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: two instances share stimulus (A: fwd, 3-cycle load stall; B: no fwd, 4-cycle, 4-bit counter).
module tb_hazard_ctrl;
  import hazard_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  logic [4:0] rs1, rs2, ex_rd, mem_rd;
  logic       rs1_u, rs2_u, ex_rw, ex_mr, mc_op, mc_done, mem_rw, redir;

  hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) if_a ();
  hazard_ctrl_if #(.REG_AW(5), .CNT_W(4))  if_b ();

  hazard_ctrl #(.REG_AW(5), .FWD_EN(1'b1), .LOAD_STALL(3), .CNT_W(16)) u_a (
    .clk (clk), .rst (rst), .hz (if_a)
  );
  hazard_ctrl #(.REG_AW(5), .FWD_EN(1'b0), .LOAD_STALL(4), .CNT_W(4)) u_b (
    .clk (clk), .rst (rst), .hz (if_b)
  );

  assign if_a.ifid_rs1 = rs1;        assign if_b.ifid_rs1 = rs1;
  assign if_a.ifid_rs2 = rs2;        assign if_b.ifid_rs2 = rs2;
  assign if_a.ifid_rs1_used = rs1_u; assign if_b.ifid_rs1_used = rs1_u;
  assign if_a.ifid_rs2_used = rs2_u; assign if_b.ifid_rs2_used = rs2_u;
  assign if_a.idex_rd = ex_rd;       assign if_b.idex_rd = ex_rd;
  assign if_a.idex_regwrite = ex_rw; assign if_b.idex_regwrite = ex_rw;
  assign if_a.idex_memread = ex_mr;  assign if_b.idex_memread = ex_mr;
  assign if_a.idex_mc_op = mc_op;    assign if_b.idex_mc_op = mc_op;
  assign if_a.mc_done = mc_done;     assign if_b.mc_done = mc_done;
  assign if_a.exmem_rd = mem_rd;     assign if_b.exmem_rd = mem_rd;
  assign if_a.exmem_regwrite = mem_rw; assign if_b.exmem_regwrite = mem_rw;
  assign if_a.ex_redirect = redir;   assign if_b.ex_redirect = redir;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    rs1 = '0; rs2 = '0; ex_rd = '0; mem_rd = '0;
    rs1_u = 0; rs2_u = 0; ex_rw = 0; ex_mr = 0;
    mc_op = 0; mc_done = 0; mem_rw = 0; redir = 0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr();
    nxt();
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    chk("inv_a_hold", 32'(if_a.ifid_hold), 32'(if_a.pc_hold));
    chk("inv_b_hold", 32'(if_b.ifid_hold), 32'(if_b.pc_hold));
    chk("inv_a_idex", 32'(if_a.idex_hold & if_a.idex_bubble), 32'd0);
    chk("inv_b_idex", 32'(if_b.idex_hold & if_b.idex_bubble), 32'd0);
    chk("inv_a_flush", 32'(if_a.ifid_flush & if_a.ifid_hold), 32'd0);
    chk("inv_b_flush", 32'(if_b.ifid_flush & if_b.ifid_hold), 32'd0);
    if (!rst && redir && u_a.r_state == MC_BUSY)
      chk("mc_redir_ignored", 32'(if_a.ifid_flush), 32'd0);
  end

  initial begin
    clr();
    // reset with hazardous inputs present: everything must stay low
    mc_op = 1; redir = 1; ex_mr = 1; ex_rw = 1; ex_rd = 5; rs2 = 5; rs2_u = 1;
    @(negedge clk);
    chk("rst_a_pc", 32'(if_a.pc_hold), 0);
    chk("rst_a_flush", 32'(if_a.ifid_flush), 0);
    chk("rst_a_bub", 32'(if_a.idex_bubble), 0);
    chk("rst_a_exb", 32'(if_a.exmem_bubble), 0);
    chk("rst_b_pc", 32'(if_b.pc_hold), 0);
    chk("rst_a_cnt", 32'(if_a.stall_cycles), 0);
    nxt();
    do_reset();

    // load-use: A stalls 3 cycles, B stalls 4
    for (int c = 0; c < 5; c++) begin
      if (c == 0) begin
        ex_mr = 1; ex_rw = 1; ex_rd = 5; rs2 = 5; rs2_u = 1;
      end else begin
        ex_mr = 0; ex_rw = 0; ex_rd = 0;
      end
      @(negedge clk);
      chk($sformatf("lu_a_pc%0d", c), 32'(if_a.pc_hold), 32'(c < 3));
      chk($sformatf("lu_a_bub%0d", c), 32'(if_a.idex_bubble), 32'(c < 3));
      chk($sformatf("lu_a_ihold%0d", c), 32'(if_a.idex_hold), 0);
      chk($sformatf("lu_b_pc%0d", c), 32'(if_b.pc_hold), 32'(c < 4));
      nxt();
    end
    chk("lu_a_cnt", 32'(if_a.stall_cycles), 3);
    chk("lu_b_cnt", 32'(if_b.stall_cycles), 4);
    do_reset();

    // x0 and unused-source filtering
    ex_mr = 1; ex_rw = 1; ex_rd = 0; rs1 = 0; rs1_u = 1; rs2 = 0; rs2_u = 1;
    @(negedge clk);
    chk("x0_a_pc", 32'(if_a.pc_hold), 0);
    chk("x0_b_pc", 32'(if_b.pc_hold), 0);
    nxt();
    ex_rd = 7; rs1 = 7; rs1_u = 0; rs2 = 3; rs2_u = 1;
    @(negedge clk);
    chk("unused_a_pc", 32'(if_a.pc_hold), 0);
    chk("unused_b_pc", 32'(if_b.pc_hold), 0);
    nxt();
    do_reset();

    // multi-cycle op, done on 5th cycle; redirect mid-busy is ignored
    for (int c = 0; c < 6; c++) begin
      mc_op = (c < 5); mc_done = (c == 4); redir = (c == 2);
      @(negedge clk);
      chk($sformatf("mc_a_pc%0d", c), 32'(if_a.pc_hold), 32'(c < 4));
      chk($sformatf("mc_a_ihold%0d", c), 32'(if_a.idex_hold), 32'(c < 4));
      chk($sformatf("mc_a_exb%0d", c), 32'(if_a.exmem_bubble), 32'(c < 4));
      chk($sformatf("mc_a_bub%0d", c), 32'(if_a.idex_bubble), 0);
      chk($sformatf("mc_b_flush%0d", c), 32'(if_b.ifid_flush), 0);
      chk($sformatf("mc_b_pc%0d", c), 32'(if_b.pc_hold), 32'(c < 4));
      if (c == 5) chk("mc_a_state", 32'(u_a.r_state), 32'(IDLE));
      nxt();
    end
    chk("mc_a_cnt", 32'(if_a.stall_cycles), 4);
    chk("mc_b_cnt", 32'(if_b.stall_cycles), 4);
    do_reset();

    // redirect aborts load-use wait on the 2nd stall cycle
    ex_mr = 1; ex_rw = 1; ex_rd = 5; rs2 = 5; rs2_u = 1;
    @(negedge clk);
    chk("rd_b_pc0", 32'(if_b.pc_hold), 1);
    nxt();
    ex_mr = 0; ex_rw = 0; ex_rd = 0; redir = 1;
    @(negedge clk);
    chk("rd_b_flush", 32'(if_b.ifid_flush), 1);
    chk("rd_b_bub", 32'(if_b.idex_bubble), 1);
    chk("rd_b_pc1", 32'(if_b.pc_hold), 0);
    chk("rd_a_flush", 32'(if_a.ifid_flush), 1);
    chk("rd_a_pc1", 32'(if_a.pc_hold), 0);
    nxt();
    redir = 0;
    @(negedge clk);
    chk("rd_b_state", 32'(u_b.r_state), 32'(IDLE));
    chk("rd_b_pc2", 32'(if_b.pc_hold), 0);
    chk("rd_a_pc2", 32'(if_a.pc_hold), 0);
    nxt();
    chk("rd_b_cnt", 32'(if_b.stall_cycles), 1);
    chk("rd_a_cnt", 32'(if_a.stall_cycles), 1);
    do_reset();

    // non-forwarding RAW stalls only on B
    mem_rw = 1; mem_rd = 3; rs1 = 3; rs1_u = 1;
    @(negedge clk);
    chk("fwd_a_pc_mem", 32'(if_a.pc_hold), 0);
    chk("fwd_b_pc_mem", 32'(if_b.pc_hold), 1);
    chk("fwd_b_bub_mem", 32'(if_b.idex_bubble), 1);
    chk("fwd_b_ihold_mem", 32'(if_b.idex_hold), 0);
    nxt();
    mem_rw = 0; ex_rw = 1; ex_rd = 3;
    @(negedge clk);
    chk("fwd_a_pc_ex", 32'(if_a.pc_hold), 0);
    chk("fwd_b_pc_ex", 32'(if_b.pc_hold), 1);
    nxt();
    ex_rd = 0; rs1 = 0;
    @(negedge clk);
    chk("fwd_b_pc_x0", 32'(if_b.pc_hold), 0);
    nxt();
    do_reset();

    // saturation: 20 stall cycles into a 4-bit counter
    mem_rw = 1; mem_rd = 3; rs1 = 3; rs1_u = 1;
    for (int c = 0; c < 20; c++) begin
      if (c == 10) chk("sat_b_cnt10", 32'(if_b.stall_cycles), 10);
      nxt();
    end
    clr();
    chk("sat_b_cnt", 32'(if_b.stall_cycles), 15);
    chk("sat_a_cnt", 32'(if_a.stall_cycles), 0);

    // reset during MC_BUSY
    mc_op = 1;
    nxt();
    @(negedge clk);
    chk("mr_a_busy", 32'(if_a.pc_hold), 1);
    nxt();
    rst = 1;
    @(negedge clk);
    chk("mr_a_pc", 32'(if_a.pc_hold), 0);
    chk("mr_a_ihold", 32'(if_a.idex_hold), 0);
    chk("mr_a_exb", 32'(if_a.exmem_bubble), 0);
    chk("mr_b_pc", 32'(if_b.pc_hold), 0);
    nxt();
    rst = 0; mc_op = 0; mc_done = 0;
    @(negedge clk);
    chk("mr_a_state", 32'(u_a.r_state), 32'(IDLE));
    chk("mr_b_state", 32'(u_b.r_state), 32'(IDLE));
    chk("mr_a_pc2", 32'(if_a.pc_hold), 0);
    chk("mr_a_cnt", 32'(if_a.stall_cycles), 0);
    chk("mr_b_cnt", 32'(if_b.stall_cycles), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Parametrised pipeline hazard unit for the 5-stage pipelined CPU. It replaces the purely combinational stall logic. It adds:
- source-use qualification and x0 filtering
- an N-cycle load-use stall counter
- a multi-cycle EX-unit (mul/div) busy handshake
- branch-redirect flushing
- a forwarding/non-forwarding mode
- a saturating stall-cycle performance counter

It sits beside the pipeline registers and drives their hold, flush and bubble controls.

Parameters:
REG_AW, 5, register-address width
FWD_EN, 1, 1 = forwarding present (only load-use stalls); 0 = stall on any RAW against EX or MEM
LOAD_STALL, 1, total bubble cycles per load-use hazard; legal range 1..7
CNT_W, 16, width of the stall performance counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
ifid_rs1  in  REG_AW  rs1 of the instruction in ID
ifid_rs2  in  REG_AW  rs2 of the instruction in ID
ifid_rs1_used  in  1  ID instruction reads rs1
ifid_rs2_used  in  1  ID instruction reads rs2
idex_rd  in  REG_AW  rd of the instruction in EX
idex_regwrite  in  1  EX instruction writes rd
idex_memread  in  1  EX instruction is a load
idex_mc_op  in  1  EX holds a multi-cycle op
mc_done  in  1  multi-cycle unit result valid this cycle
exmem_rd  in  REG_AW  rd of the instruction in MEM
exmem_regwrite  in  1  MEM instruction writes rd
ex_redirect  in  1  branch/jump mispredict resolved in EX
pc_hold  out  1  freeze PC
ifid_hold  out  1  freeze IF/ID
ifid_flush  out  1  zero IF/ID
idex_hold  out  1  freeze ID/EX
idex_bubble  out  1  load NOP into ID/EX
exmem_bubble  out  1  load NOP into EX/MEM
stall_cycles  out  CNT_W  saturating count of cycles with pc_hold=1

Behaviour:
- One clock domain: clk. Reset is synchronous, active-high, on rst.
- While rst=1: state=IDLE, lu_cnt=0, stall_cycles=0, and every control output is forced to 0.
- Control outputs are combinational from state and inputs. State, lu_cnt and stall_cycles are registered.
- Match helpers:
  - matchX(rd) = (rd != 0) && ((ifid_rs1_used && rd == ifid_rs1) || (ifid_rs2_used && rd == ifid_rs2)).
  - Register x0 never causes a hazard.
- FSM states: IDLE, LU_WAIT, MC_BUSY.
- Output decisions are evaluated in priority order; the first matching rule applies.
  1. MC_BUSY, or IDLE with idex_mc_op=1 and mc_done=0:
     - Assert pc_hold, ifid_hold, idex_hold, exmem_bubble.
     - Next state is MC_BUSY.
     - In MC_BUSY, the cycle with mc_done=1 drives all outputs 0 and returns to IDLE.
     - idex_mc_op=1 together with mc_done=1 in IDLE is single-cycle completion: no stall.
  2. ex_redirect=1 (IDLE or LU_WAIT):
     - Assert ifid_flush and idex_bubble. Holds are 0.
     - Next state is IDLE and lu_cnt is cleared. Redirect aborts any pending load-use wait.
  3. LU_WAIT:
     - Assert pc_hold, ifid_hold, idex_bubble.
     - lu_cnt decrements each cycle. Leave to IDLE on the cycle lu_cnt==1, which is still a stall cycle.
  4. IDLE with idex_memread && idex_regwrite && matchX(idex_rd) (load-use):
     - Assert pc_hold, ifid_hold, idex_bubble.
     - If LOAD_STALL>1: lu_cnt <= LOAD_STALL-1 and go to LU_WAIT. Otherwise stay in IDLE.
     - Total stall is exactly LOAD_STALL cycles.
  5. FWD_EN=0 only, in IDLE:
     - Condition: (idex_regwrite && matchX(idex_rd)) || (exmem_regwrite && matchX(exmem_rd)).
     - Assert pc_hold, ifid_hold, idex_bubble. Stateless; the stall re-evaluates every cycle.
  6. Otherwise all control outputs are 0.
- Invariants:
  - ifid_hold == pc_hold at all times.
  - idex_hold and idex_bubble are never both 1.
  - ifid_flush and ifid_hold are never both 1.
- stall_cycles:
  - Increments on every cycle with pc_hold=1.
  - Saturates at 2^CNT_W-1, with no wrap-around.
- ex_redirect during MC_BUSY is a protocol violation. It is ignored and covered by a bench assertion.
- rst asserted mid-stall returns the block to IDLE on the next edge, with no residual stall.

Decomposition:
- Package hazard_pkg holds:
  - state enum (IDLE, LU_WAIT, MC_BUSY)
  - ZERO_REG constant
  - a function implementing matchX
- One natural sub-module: sat_counter (parameter W; inputs clk, rst, inc; output count). Used for stall_cycles.

Test Plan:
- Load-use: LOAD_STALL=3; idex_memread=1, idex_regwrite=1, idex_rd=5, ifid_rs2=5, rs2_used=1 -> pc_hold/idex_bubble high exactly 3 cycles; stall_cycles=3.
- x0 and unused-source filtering: idex_rd=0 with a load; then rd=7 matching ifid_rs1=7 but rs1_used=0 -> no stall in either case.
- Multi-cycle op: idex_mc_op=1, mc_done asserted on the 5th cycle -> pc_hold, idex_hold and exmem_bubble high for 4 cycles, low on the mc_done cycle, state back to IDLE.
- Redirect abort: LOAD_STALL=4, ex_redirect=1 on the 2nd stall cycle -> that cycle ifid_flush=1, idex_bubble=1, pc_hold=0; state IDLE next cycle; stall_cycles=1.
- FWD_EN=0: exmem_regwrite=1, exmem_rd=3, ifid_rs1=3, rs1_used=1 -> stall; with FWD_EN=1 and the same stimulus -> no stall.
- Saturation and reset: CNT_W=4, 20 stall cycles -> stall_cycles=15; rst=1 during MC_BUSY -> all outputs 0 that cycle; next cycle state IDLE and stall_cycles=0.
